vga_timing_gen: RTL

Parametrised VGA raster timing generator. It produces HSYNC and VSYNC with configurable polarity, an active-video qualifier, and line and frame strobes. It also produces pixel column/row addresses that lead the active-video window by a configurable number of cycles, so a downstream pattern generator or ROM with registered latency lines up with the display window. It sits between the pixel-clock domain and the display/pattern modules of the VGA designs, and supersedes the fixed-timing sync generator.

---
 rtl/vga_timing_pkg.sv | 51 +++++
 rtl/vga_axis_counter.sv | 50 +++++
 rtl/vga_timing_gen.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared definitions for the VGA raster timing generator:
//   - axis_timing_t / vga_mode_t describe one display mode as sync, back
//     porch, active and front porch lengths for each axis.
//   - MODE_* localparams hold the standard mode tables.
//   - addr_width() returns the bit width needed to hold the values 0..n-1.
//   - max_u() is an elaboration-time maximum used for width selection.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned sync;
    int unsigned back;
    int unsigned active;
    int unsigned front;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } vga_mode_t;

  localparam vga_mode_t MODE_640X480_60 = '{
    h: '{sync: 96, back: 48, active: 640, front: 16},
    v: '{sync: 2, back: 33, active: 480, front: 10}
  };

  localparam vga_mode_t MODE_800X600_60 = '{
    h: '{sync: 128, back: 88, active: 800, front: 40},
    v: '{sync: 4, back: 23, active: 600, front: 1}
  };

  localparam vga_mode_t MODE_800X600_72 = '{
    h: '{sync: 120, back: 64, active: 800, front: 56},
    v: '{sync: 6, back: 23, active: 600, front: 37}
  };

  localparam vga_mode_t MODE_1024X768_60 = '{
    h: '{sync: 136, back: 160, active: 1024, front: 24},
    v: '{sync: 6, back: 29, active: 768, front: 3}
  };

  // Bits needed to represent every value 0..n-1 (at least one bit).
  function automatic int unsigned addr_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   One raster axis (horizontal or vertical). Counts 0..len-1 while inc is
//   high and decodes the region the count currently sits in. Region order
//   is sync, back porch, active, front porch.
// Ports:
//   CLK       in   pixel clock
//   RSTn      in   asynchronous active-low reset (count -> 0)
//   inc       in   advance the count on this edge
//   len       in   wrap length (count runs 0..len-1)
//   count     out  current position on the axis
//   last      out  count is len-1 (next advance wraps to 0)
//   in_sync   out  count lies in the sync region
//   in_active out  count lies in the active region
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned SYNC   = 1,
  parameter int unsigned BACK   = 1,
  parameter int unsigned ACTIVE = 1,
  parameter int unsigned FRONT  = 1,
  parameter int unsigned MIN_W  = 1,
  localparam int unsigned CNT_W = max_u(MIN_W, addr_width(SYNC + BACK + ACTIVE + FRONT))
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             inc,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] count,
  output logic             last,
  output logic             in_sync,
  output logic             in_active
);

  localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] ACT_START = CNT_W'(SYNC + BACK);
  localparam logic [CNT_W-1:0] ACT_END   = CNT_W'(SYNC + BACK + ACTIVE);

  assign last      = (count == len - CNT_W'(1));
  assign in_sync   = (count < SYNC_END);
  assign in_active = (count >= ACT_START) && (count < ACT_END);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      count <= '0;
    end else if (inc) begin
      count <= last ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator. Two axis counters track the
//   raster position; this level decodes syncs, the active window, a
//   lookahead request window with pixel addresses, and line/frame strobes.
//   Every output is registered from the counter state ahead of the same
//   clock edge, so pins lag the counters by one enabled cycle.
// Ports:
//   CLK              in   pixel clock
//   RSTn             in   asynchronous active-low reset
//   En               in   pixel-clock enable; low freezes the raster
//   HSYNC_Sig        out  horizontal sync (asserted level H_POL)
//   VSYNC_Sig        out  vertical sync (asserted level V_POL)
//   Ready_Sig        out  current pixel is visible
//   Req_Sig          out  addresses valid, LEAD cycles ahead of Ready_Sig
//   Column_Addr_Sig  out  column of requested pixel, 0 when Req_Sig=0
//   Row_Addr_Sig     out  row of requested pixel, 0 when Req_Sig=0
//   Line_Sig         out  one-cycle pulse on the last pixel of each line
//   Frame_Sig        out  one-cycle pulse on the last pixel of each frame
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = MODE_800X600_72.h.sync,
  parameter int unsigned H_BACK   = MODE_800X600_72.h.back,
  parameter int unsigned H_ACTIVE = MODE_800X600_72.h.active,
  parameter int unsigned H_FRONT  = MODE_800X600_72.h.front,
  parameter int unsigned V_SYNC   = MODE_800X600_72.v.sync,
  parameter int unsigned V_BACK   = MODE_800X600_72.v.back,
  parameter int unsigned V_ACTIVE = MODE_800X600_72.v.active,
  parameter int unsigned V_FRONT  = MODE_800X600_72.v.front,
  parameter bit          H_POL    = 1'b1,
  parameter bit          V_POL    = 1'b1,
  parameter int unsigned LEAD     = 1,
  parameter int unsigned ADDR_W   = 11
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              En,
  output logic              HSYNC_Sig,
  output logic              VSYNC_Sig,
  output logic              Ready_Sig,
  output logic              Req_Sig,
  output logic [ADDR_W-1:0] Column_Addr_Sig,
  output logic [ADDR_W-1:0] Row_Addr_Sig,
  output logic              Line_Sig,
  output logic              Frame_Sig
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  // Wide enough for h+LEAD without overflow, and never narrower than ADDR_W+1
  // so the address subtraction always has a spare top bit.
  localparam int unsigned AXIS_W =
    max_u(ADDR_W + 1, max_u(addr_width(H_TOTAL + LEAD), addr_width(V_TOTAL)));

  localparam logic [AXIS_W-1:0] H_LEN     = AXIS_W'(H_TOTAL);
  localparam logic [AXIS_W-1:0] V_LEN     = AXIS_W'(V_TOTAL);
  localparam logic [AXIS_W-1:0] H_START_C = AXIS_W'(H_SYNC + H_BACK);
  localparam logic [AXIS_W-1:0] H_END_C   = AXIS_W'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [AXIS_W-1:0] V_START_C = AXIS_W'(V_SYNC + V_BACK);
  localparam logic [AXIS_W-1:0] LEAD_C    = AXIS_W'(LEAD);

  logic [AXIS_W-1:0] h;
  logic [AXIS_W-1:0] v;
  logic              h_last;
  logic              v_last;
  logic              h_sync;
  logic              v_sync;
  logic              h_act;
  logic              v_act;

  vga_axis_counter #(
    .SYNC  (H_SYNC),
    .BACK  (H_BACK),
    .ACTIVE(H_ACTIVE),
    .FRONT (H_FRONT),
    .MIN_W (AXIS_W)
  ) u_h_axis (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .inc      (En),
    .len      (H_LEN),
    .count    (h),
    .last     (h_last),
    .in_sync  (h_sync),
    .in_active(h_act)
  );

  // The vertical axis steps once per line, on the horizontal wrap.
  vga_axis_counter #(
    .SYNC  (V_SYNC),
    .BACK  (V_BACK),
    .ACTIVE(V_ACTIVE),
    .FRONT (V_FRONT),
    .MIN_W (AXIS_W)
  ) u_v_axis (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .inc      (En & h_last),
    .len      (V_LEN),
    .count    (v),
    .last     (v_last),
    .in_sync  (v_sync),
    .in_active(v_act)
  );

  // Lookahead decode: the request window is the active window evaluated at
  // h+LEAD. LEAD never exceeds the back porch, so it stays on the same line.
  logic [AXIS_W-1:0] hl;
  logic [AXIS_W-1:0] col_full;
  logic [AXIS_W-1:0] row_full;
  logic              req_next;

  always_comb begin
    hl       = h + LEAD_C;
    req_next = (hl >= H_START_C) && (hl < H_END_C) && v_act;
    col_full = '0;
    row_full = '0;
    if (req_next) begin
      col_full = hl - H_START_C;
      row_full = v - V_START_C;
    end
  end

  // Addresses fit in ADDR_W bits whenever the request is valid; the spare
  // top bits of the wide arithmetic are always zero.
  logic unused_addr_msbs;
  assign unused_addr_msbs = &{1'b0, col_full[AXIS_W-1:ADDR_W], row_full[AXIS_W-1:ADDR_W]};

  // Output register stage. Strobes are cleared on disabled edges so each
  // line/frame event appears for exactly one clock.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      HSYNC_Sig       <= ~H_POL;
      VSYNC_Sig       <= ~V_POL;
      Ready_Sig       <= 1'b0;
      Req_Sig         <= 1'b0;
      Column_Addr_Sig <= '0;
      Row_Addr_Sig    <= '0;
      Line_Sig        <= 1'b0;
      Frame_Sig       <= 1'b0;
    end else if (En) begin
      HSYNC_Sig       <= h_sync ? H_POL : ~H_POL;
      VSYNC_Sig       <= v_sync ? V_POL : ~V_POL;
      Ready_Sig       <= h_act & v_act;
      Req_Sig         <= req_next;
      Column_Addr_Sig <= col_full[ADDR_W-1:0];
      Row_Addr_Sig    <= row_full[ADDR_W-1:0];
      Line_Sig        <= h_last;
      Frame_Sig       <= h_last & v_last;
    end else begin
      Line_Sig        <= 1'b0;
      Frame_Sig       <= 1'b0;
    end
  end

endmodule
